inst_rom_responder: RTL and testbench

- Memory-side responder for the instruction fetch interface: receives the word address issued by the fetch stage and returns the 32-bit instruction word one clock later.
- Also contains the program-download path. A byte stream, for example from the UART upgrade controller, is assembled little-endian into words and written sequentially from word 0.
- Sits between the fetch stage and the 64 KB RAMROM array. It owns the array storage.

---
 rtl/inst_rom_responder.sv | 139 +++++++++++++
 tb/tb_inst_rom_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_responder.sv
// Instruction ROM responder: one-cycle fetch read plus byte-stream program download.
// Optional macro UPG_CHECKSUM_EN adds an 8-bit running sum of downloaded bytes.
module inst_rom_responder #(
  parameter int          ADDR_W    = 14,
  parameter int          DEPTH     = 16384,
  parameter logic [31:0] IDLE_WORD = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rom_adr_i,
  output logic [31:0]       Jpadr,
  input  logic              upg_en_i,
  input  logic              upg_valid_i,
  input  logic [7:0]        upg_byte_i,
  output logic              upg_ready_o,
  input  logic              upg_done_i,
  output logic              busy_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic              overflow_o,
  output logic [7:0]        checksum_o
);

  typedef enum logic [1:0] {SERVE, LOAD, FLUSH} state_t;

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic [31:0]       mem [DEPTH];
  state_t            state_q, state_d;
  logic [31:0]       jpadr_q, jpadr_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [23:0]       asm_q, asm_d;
  logic              ovf_q, ovf_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  always_comb begin
    state_d = state_q;
    jpadr_d = IDLE_WORD;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    waddr   = ptr_q[ADDR_W-1:0];
    wdata   = {upg_byte_i, asm_q};
    case (state_q)
      SERVE: begin
        jpadr_d = mem[Rom_adr_i];
        if (upg_en_i) begin
          state_d = LOAD;
          idx_d   = 2'd0;
          ptr_d   = '0;
          asm_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (upg_valid_i) begin
          // Pointer saturates at DEPTH; further bytes only raise the sticky flag.
          if (ptr_q == FULL) begin
            ovf_d = 1'b1;
          end else if (idx_q == 2'd3) begin
            we    = 1'b1;
            ptr_d = ptr_q + 1'b1;
            idx_d = 2'd0;
            asm_d = '0;
          end else begin
            asm_d[8*idx_q +: 8] = upg_byte_i;
            idx_d = idx_q + 2'd1;
          end
        end
        if (upg_done_i || !upg_en_i) state_d = FLUSH;
      end
      FLUSH: begin
        // Unfilled upper bytes are already zero because asm is cleared per word.
        wdata = {8'h00, asm_q};
        if ((idx_q != 2'd0) && (ptr_q != FULL)) begin
          we    = 1'b1;
          ptr_d = ptr_q + 1'b1;
        end
        idx_d   = 2'd0;
        asm_d   = '0;
        state_d = SERVE;
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SERVE;
      jpadr_q <= 32'h0;
      idx_q   <= 2'd0;
      ptr_q   <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      jpadr_q <= jpadr_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is never reset; a reset edge only suppresses the pending write.
  always_ff @(posedge clock) begin
    if (we && !reset) mem[waddr] <= wdata;
  end

`ifdef UPG_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == SERVE && upg_en_i) csum_d = 8'h00;
    else if (state_q == LOAD && upg_valid_i) csum_d = csum_q + upg_byte_i;
  end

  always_ff @(posedge clock) begin
    if (reset) csum_q <= 8'h00;
    else       csum_q <= csum_d;
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = 8'h00;
`endif

  assign Jpadr          = jpadr_q;
  assign upg_ready_o    = (state_q == LOAD);
  assign busy_o         = (state_q != SERVE);
  assign words_loaded_o = ptr_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Scoreboard bench for inst_rom_responder: full-size instance plus a DEPTH=16 instance for overflow.
module tb_inst_rom_responder;

  logic        clk;
  logic        reset;

  logic [13:0] adr_a;
  logic [31:0] jp_a;
  logic        en_a, v_a, done_a, ready_a, busy_a, ovf_a;
  logic [7:0]  b_a, cs_a;
  logic [14:0] wl_a;

  logic [3:0]  adr_b;
  logic [31:0] jp_b;
  logic        en_b, v_b, done_b, ready_b, busy_b, ovf_b;
  logic [7:0]  b_b, cs_b;
  logic [4:0]  wl_b;

  int total = 0;
  int bad   = 0;

  logic        fv_a = 1'b0, pend_a = 1'b0;
  logic        fv_b = 1'b0, pend_b = 1'b0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  inst_rom_responder dut_a (
    .clock(clk), .reset(reset), .Rom_adr_i(adr_a), .Jpadr(jp_a),
    .upg_en_i(en_a), .upg_valid_i(v_a), .upg_byte_i(b_a), .upg_ready_o(ready_a),
    .upg_done_i(done_a), .busy_o(busy_a), .words_loaded_o(wl_a),
    .overflow_o(ovf_a), .checksum_o(cs_a)
  );

  inst_rom_responder #(.ADDR_W(4), .DEPTH(16)) dut_b (
    .clock(clk), .reset(reset), .Rom_adr_i(adr_b), .Jpadr(jp_b),
    .upg_en_i(en_b), .upg_valid_i(v_b), .upg_byte_i(b_b), .upg_ready_o(ready_b),
    .upg_done_i(done_b), .busy_o(busy_b), .words_loaded_o(wl_b),
    .overflow_o(ovf_b), .checksum_o(cs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fetch monitors: a request issued before an edge is answered at the next falling edge.
  always @(posedge clk) begin
    pend_a <= fv_a;
    pend_b <= fv_b;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (pend_a) begin
      total++;
      if (q_a.size() == 0) begin
        bad++;
        $display("FAIL sb_a_empty actual=%h required=<none>", jp_a);
      end else begin
        e = q_a.pop_front();
        if (jp_a !== e) begin
          bad++;
          $display("FAIL jpadr_a actual=%h required=%h t=%0t", jp_a, e, $time);
        end
      end
    end
    if (pend_b) begin
      total++;
      if (q_b.size() == 0) begin
        bad++;
        $display("FAIL sb_b_empty actual=%h required=<none>", jp_b);
      end else begin
        e = q_b.pop_front();
        if (jp_b !== e) begin
          bad++;
          $display("FAIL jpadr_b actual=%h required=%h t=%0t", jp_b, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cs(input logic [7:0] v);
`ifdef UPG_CHECKSUM_EN
    return 32'(v);
`else
    return 32'(v & 8'h00);
`endif
  endfunction

  task automatic send_a(input logic [7:0] b);
    v_a = 1'b1;
    b_a = b;
    tick();
    v_a = 1'b0;
  endtask

  task automatic send_word_a(input logic [31:0] w);
    send_a(w[7:0]);
    send_a(w[15:8]);
    send_a(w[23:16]);
    send_a(w[31:24]);
  endtask

  task automatic finish_a();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    en_a   = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_a(input logic [13:0] a, input logic [31:0] e);
    fv_a  = 1'b1;
    adr_a = a;
    q_a.push_back(e);
    tick();
    fv_a  = 1'b0;
  endtask

  task automatic read_b(input logic [3:0] a, input logic [31:0] e);
    fv_b  = 1'b1;
    adr_b = a;
    q_b.push_back(e);
    tick();
    fv_b  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] full_bytes [8];
    logic [31:0] b2b [4];
    full_bytes = '{8'h0A, 8'h00, 8'h08, 8'h24, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    b2b = '{32'h2408000A, 32'hFFFFFFFF, 32'h10000002, 32'h10000003};

    reset = 1'b1;
    adr_a = '0; en_a = 1'b0; v_a = 1'b0; b_a = '0; done_a = 1'b0;
    adr_b = '0; en_b = 1'b0; v_b = 1'b0; b_b = '0; done_b = 1'b0;
    tick();
    tick();
    check("rst_jpadr", jp_a, 32'h0);
    check("rst_ready", 32'(ready_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_words", 32'(wl_a), 32'h0);
    check("rst_ovf", 32'(ovf_a), 32'h0);
    reset = 1'b0;
    tick();

    // Preload six words; word 5 holds the instruction used by the reset/read test.
    en_a = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) send_word_a(32'h1000_0000 + 32'(k));
    send_word_a(32'h2408000A);
    finish_a();
    check("preload_words", 32'(wl_a), 32'd6);

    // Reset then read: zero during reset, data one edge after reset releases.
    adr_a = 14'd5;
    fv_a  = 1'b1;
    reset = 1'b1;
    q_a.push_back(32'h0);
    tick();
    q_a.push_back(32'h0);
    tick();
    reset = 1'b0;
    q_a.push_back(32'h2408000A);
    tick();
    fv_a = 1'b0;
    check("rr_words", 32'(wl_a), 32'h0);

    // Full download with IDLE_WORD observed throughout LOAD and FLUSH.
    en_a = 1'b1;
    tick();
    check("load_busy", 32'(busy_a), 32'h1);
    check("load_ready", 32'(ready_a), 32'h1);
    fv_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v_a = 1'b1;
      b_a = full_bytes[i];
      q_a.push_back(32'h0);
      tick();
    end
    v_a = 1'b0;
    done_a = 1'b1;
    q_a.push_back(32'h0);
    tick();
    done_a = 1'b0;
    en_a   = 1'b0;
    check("flush_ready", 32'(ready_a), 32'h0);
    check("flush_busy", 32'(busy_a), 32'h1);
    q_a.push_back(32'h0);
    tick();
    check("full_words", 32'(wl_a), 32'd2);
    check("full_ovf", 32'(ovf_a), 32'h0);
    check("full_cs", 32'(cs_a), exp_cs(8'h32));
    check("full_busy", 32'(busy_a), 32'h0);
    for (int i = 0; i < 4; i++) begin
      adr_a = 14'(i);
      q_a.push_back(b2b[i]);
      tick();
    end
    fv_a = 1'b0;

    // Partial word padded with zeros in FLUSH.
    en_a = 1'b1;
    tick();
    send_a(8'h11);
    send_a(8'h22);
    send_a(8'h33);
    finish_a();
    check("part_words", 32'(wl_a), 32'd1);
    check("part_cs", 32'(cs_a), exp_cs(8'h66));
    read_a(14'd0, 32'h00332211);
    read_a(14'd1, 32'hFFFFFFFF);

    // Reset mid-load: first word kept, partial second word discarded.
    en_a = 1'b1;
    tick();
    send_a(8'hAA); send_a(8'hBB); send_a(8'hCC);
    send_a(8'hDD); send_a(8'hEE); send_a(8'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en_a  = 1'b0;
    tick();
    check("rml_busy", 32'(busy_a), 32'h0);
    check("rml_ready", 32'(ready_a), 32'h0);
    check("rml_words", 32'(wl_a), 32'h0);
    read_a(14'd0, 32'hDDCCBBAA);
    read_a(14'd1, 32'hFFFFFFFF);

    // Dropping upg_en_i ends the download like upg_done_i.
    en_a = 1'b1;
    tick();
    send_a(8'h01); send_a(8'h02); send_a(8'h03); send_a(8'h04); send_a(8'h05);
    en_a = 1'b0;
    tick();
    tick();
    check("endrop_words", 32'(wl_a), 32'd2);
    read_a(14'd0, 32'h04030201);
    read_a(14'd1, 32'h00000005);

    // Overflow on the 16-word instance.
    en_b = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      v_b = 1'b1;
      b_b = 8'(i);
      tick();
    end
    check("ovf_before", 32'(ovf_b), 32'h0);
    check("ovf_words16", 32'(wl_b), 32'd16);
    b_b = 8'h40;
    tick();
    v_b = 1'b0;
    check("ovf_set", 32'(ovf_b), 32'h1);
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    en_b   = 1'b0;
    tick();
    tick();
    check("ovf_words_end", 32'(wl_b), 32'd16);
    check("ovf_sticky", 32'(ovf_b), 32'h1);
    check("ovf_cs", 32'(cs_b), exp_cs(8'h20));
    read_b(4'd0, 32'h03020100);
    read_b(4'd15, 32'h3F3E3D3C);

    repeat (3) tick();
    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL sb_drain actual=%0d required=0", q_a.size() + q_b.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
